seq_compare: RTL and testbench



---
 rtl/seq_compare_if.sv | 39 +++
 rtl/seq_compare.sv | 151 +++++++++++++++
 tb/tb_seq_compare.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_compare_if.sv
// Operand/result bundle for seq_compare.
// Master drives samples; slave returns registered results and history.
interface seq_compare_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             mode_signed;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] min_a;
  logic [WIDTH-1:0] max_a;
  logic             hist_valid;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] gt_cnt;

  modport master (
    output in_valid, mode_signed, clear, a, b,
    input  out_valid, lt, eq, gt, a_neg, b_neg,
    input  a_mag, b_mag, min_a, max_a,
    input  hist_valid, sample_cnt, gt_cnt
  );

  modport slave (
    input  in_valid, mode_signed, clear, a, b,
    output out_valid, lt, eq, gt, a_neg, b_neg,
    output a_mag, b_mag, min_a, max_a,
    output hist_valid, sample_cnt, gt_cnt
  );
endinterface

// File: rtl/seq_compare.sv
// Registered signed/unsigned comparator with sign/magnitude split
// and a restartable min/max/count history of operand a.
module seq_compare #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_compare_if.slave bus
);
  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q;
  logic             ov_q, lt_q, eq_q, gt_q;
  logic             an_q, bn_q;
  logic [WIDTH-1:0] am_q, bm_q;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic [CNT_W-1:0] gc_q, gc_d;

  function automatic logic lt_f(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             s
  );
    logic [WIDTH:0] xe, ye;
    xe = {s & x[WIDTH-1], x};
    ye = {s & y[WIDTH-1], y};
    return $signed(xe) < $signed(ye);
  endfunction

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             restart;
  logic             a_lt_b, a_gt_b;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             load, upd, drop;

  assign restart = bus.clear | (bus.mode_signed != mode_q);
  assign a_lt_b  = lt_f(bus.a, bus.b, bus.mode_signed);
  assign a_gt_b  = lt_f(bus.b, bus.a, bus.mode_signed);
  assign a_neg   = bus.mode_signed & bus.a[WIDTH-1];
  assign b_neg   = bus.mode_signed & bus.b[WIDTH-1];
  assign a_mag   = a_neg ? -bus.a : bus.a;
  assign b_mag   = b_neg ? -bus.b : bus.b;

  // The three history actions are mutually exclusive by construction.
  assign load = bus.in_valid & (restart | (state_q == EMPTY));
  assign upd  = bus.in_valid & ~restart & (state_q == TRACK);
  assign drop = ~bus.in_valid & restart;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    sc_d    = sc_q;
    gc_d    = gc_q;
    unique case (1'b1)
      load: begin
        state_d = TRACK;
        min_d   = bus.a;
        max_d   = bus.a;
        sc_d    = CNT_W'(1);
        gc_d    = CNT_W'(a_gt_b);
      end
      upd: begin
        if (lt_f(bus.a, min_q, bus.mode_signed))
          min_d = bus.a;
        if (lt_f(max_q, bus.a, bus.mode_signed))
          max_d = bus.a;
        sc_d = sat(sc_q);
        if (a_gt_b)
          gc_d = sat(gc_q);
      end
      drop: begin
        state_d = EMPTY;
        min_d   = '0;
        max_d   = '0;
        sc_d    = '0;
        gc_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      mode_q  <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      sc_q    <= '0;
      gc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= bus.mode_signed;
      min_q   <= min_d;
      max_q   <= max_d;
      sc_q    <= sc_d;
      gc_q    <= gc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      am_q <= '0;
      bm_q <= '0;
    end else begin
      ov_q <= bus.in_valid;
      if (bus.in_valid) begin
        lt_q <= a_lt_b;
        eq_q <= ~a_lt_b & ~a_gt_b;
        gt_q <= a_gt_b;
        an_q <= a_neg;
        bn_q <= b_neg;
        am_q <= a_mag;
        bm_q <= b_mag;
      end
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.lt         = lt_q;
  assign bus.eq         = eq_q;
  assign bus.gt         = gt_q;
  assign bus.a_neg      = an_q;
  assign bus.b_neg      = bn_q;
  assign bus.a_mag      = am_q;
  assign bus.b_mag      = bm_q;
  assign bus.min_a      = min_q;
  assign bus.max_a      = max_q;
  assign bus.hist_valid = (state_q == TRACK);
  assign bus.sample_cnt = sc_q;
  assign bus.gt_cnt     = gc_q;
endmodule

// File: tb/tb_seq_compare.sv
// Scoreboard bench for seq_compare (WIDTH=4, CNT_W=2).
// Driver queues hand-computed results; monitor checks on out_valid.
module tb_seq_compare;
  localparam int W = 4;
  localparam int C = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  seq_compare_if #(.WIDTH(W), .CNT_W(C)) ifc ();

  seq_compare #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    int lt, eq, gt, an, bn;
    int am, bm, mn, mx;
    int hv, sc, gc;
  } exp_t;

  exp_t sq[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic send(bit s, bit clr, logic [3:0] a,
                      logic [3:0] b, exp_t e);
    @(negedge clk);
    ifc.in_valid    = 1'b1;
    ifc.mode_signed = s;
    ifc.clear       = clr;
    ifc.a           = a;
    ifc.b           = b;
    sq.push_back(e);
  endtask

  task automatic idle(bit s, bit clr);
    @(negedge clk);
    ifc.in_valid    = 1'b0;
    ifc.mode_signed = s;
    ifc.clear       = clr;
  endtask

  task automatic hist_chk(string n, int gt, int am, int hv,
                          int mn, int mx, int sc, int gc);
    @(negedge clk);
    chk({n, "_ov"}, int'(ifc.out_valid), 0);
    chk({n, "_gt"}, int'(ifc.gt), gt);
    chk({n, "_am"}, int'(ifc.a_mag), am);
    chk({n, "_hv"}, int'(ifc.hist_valid), hv);
    chk({n, "_min"}, int'(ifc.min_a), mn);
    chk({n, "_max"}, int'(ifc.max_a), mx);
    chk({n, "_sc"}, int'(ifc.sample_cnt), sc);
    chk({n, "_gc"}, int'(ifc.gt_cnt), gc);
  endtask

  task automatic rst_chk(string n);
    logic [31:0] all;
    all = {ifc.out_valid, ifc.lt, ifc.eq, ifc.gt,
           ifc.a_neg, ifc.b_neg, ifc.a_mag, ifc.b_mag,
           ifc.min_a, ifc.max_a, ifc.hist_valid,
           ifc.sample_cnt, ifc.gt_cnt};
    chk({n, "_outs"}, int'(all), 0);
    chk({n, "_hv"}, int'(ifc.hist_valid), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (sq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sq.pop_front();
        chk("lt", int'(ifc.lt), e.lt);
        chk("eq", int'(ifc.eq), e.eq);
        chk("gt", int'(ifc.gt), e.gt);
        chk("a_neg", int'(ifc.a_neg), e.an);
        chk("b_neg", int'(ifc.b_neg), e.bn);
        chk("a_mag", int'(ifc.a_mag), e.am);
        chk("b_mag", int'(ifc.b_mag), e.bm);
        chk("min_a", int'(ifc.min_a), e.mn);
        chk("max_a", int'(ifc.max_a), e.mx);
        chk("hist_valid", int'(ifc.hist_valid), e.hv);
        chk("sample_cnt", int'(ifc.sample_cnt), e.sc);
        chk("gt_cnt", int'(ifc.gt_cnt), e.gc);
      end
    end
  end

  initial begin
    ifc.in_valid    = 1'b0;
    ifc.mode_signed = 1'b0;
    ifc.clear       = 1'b0;
    ifc.a           = '0;
    ifc.b           = '0;
    #2 rst_n = 1'b0;
    #1 rst_chk("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 0);

    // most-negative operand, signed then unsigned
    send(1, 0, 4'd8, 4'd7, '{1,0,0, 1,0, 8,7, 8,8, 1,1,0});
    send(0, 0, 4'd8, 4'd7, '{0,0,1, 0,0, 8,7, 8,8, 1,1,1});

    // signed history: 3, -2, 5 against b=0
    send(1, 0, 4'd3, 4'd0, '{0,0,1, 0,0, 3,0, 3,3, 1,1,1});
    send(1, 0, 4'd14, 4'd0, '{1,0,0, 1,0, 2,0, 14,3, 1,2,1});
    send(1, 0, 4'd5, 4'd0, '{0,0,1, 0,0, 5,0, 14,5, 1,3,2});

    // mode change without a sample empties the history
    idle(0, 0);
    hist_chk("mode_restart", 1, 5, 0, 0, 0, 0, 0);
    send(0, 0, 4'd14, 4'd1, '{0,0,1, 0,0, 14,1, 14,14, 1,1,1});

    // counter saturation at 3
    send(0, 1, 4'd2, 4'd1, '{0,0,1, 0,0, 2,1, 2,2, 1,1,1});
    send(0, 0, 4'd2, 4'd1, '{0,0,1, 0,0, 2,1, 2,2, 1,2,2});
    send(0, 0, 4'd2, 4'd1, '{0,0,1, 0,0, 2,1, 2,2, 1,3,3});
    send(0, 0, 4'd2, 4'd1, '{0,0,1, 0,0, 2,1, 2,2, 1,3,3});
    send(0, 0, 4'd2, 4'd1, '{0,0,1, 0,0, 2,1, 2,2, 1,3,3});

    // clear with a sample, then unsigned min update
    send(0, 1, 4'd6, 4'd6, '{0,1,0, 0,0, 6,6, 6,6, 1,1,0});
    send(0, 0, 4'd1, 4'd9, '{1,0,0, 0,0, 1,9, 1,6, 1,2,0});

    // mode change with a sample; negative b
    send(1, 0, 4'd7, 4'd15, '{0,0,1, 0,1, 7,1, 7,7, 1,1,1});
    idle(1, 0);
    hist_chk("hold", 1, 7, 1, 7, 7, 1, 1);
    idle(1, 1);
    hist_chk("clear_idle", 1, 7, 0, 0, 0, 0, 0);

    // asynchronous reset mid-stream
    send(1, 0, 4'd4, 4'd2, '{0,0,1, 0,0, 4,2, 4,4, 1,1,1});
    @(negedge clk);
    ifc.a = 4'd1;
    ifc.b = 4'd1;
    #2 rst_n = 1'b0;
    #1 rst_chk("async_rst");
    @(negedge clk);
    ifc.in_valid = 1'b0;
    rst_n = 1'b1;
    send(1, 0, 4'd3, 4'd1, '{0,0,1, 0,0, 3,1, 3,3, 1,1,1});
    idle(1, 0);

    for (int i = 0; i < 20 && sq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
